// File: rtl/element_convert_pipe_if.sv
// Bus bundle for element_convert_pipe: control handshake, element/float RAM ports and FP core ports.
// master = the pipe itself, slave = the surrounding stage logic, RAMs and FP cores.
interface element_convert_pipe_if #(
    parameter int unsigned ADDR_W = 5
);
    logic              start_process;
    logic [ADDR_W:0]   numElements;
    logic              end_process;
    logic              busy;
    logic [ADDR_W-1:0] element_addr;
    logic [31:0]       element_out;
    logic [ADDR_W-1:0] float_register_addr;
    logic [31:0]       float_register_data;
    logic              float_register_wren;
    logic [31:0]       int_to_fp_data;
    logic [31:0]       int_to_fp_out;
    logic [31:0]       multiplier_data_a;
    logic [31:0]       multiplier_data_b;
    logic [31:0]       multiplier_out;
    logic [31:0]       divider_data_a;
    logic [31:0]       divider_data_b;
    logic [31:0]       divider_out;
    logic              conv_error;
    logic [ADDR_W-1:0] error_addr;

    modport master (
        input  start_process, numElements, element_out, int_to_fp_out, multiplier_out, divider_out,
        output end_process, busy, element_addr, float_register_addr, float_register_data,
               float_register_wren, int_to_fp_data, multiplier_data_a, multiplier_data_b,
               divider_data_a, divider_data_b, conv_error, error_addr
    );

    modport slave (
        output start_process, numElements, element_out, int_to_fp_out, multiplier_out, divider_out,
        input  end_process, busy, element_addr, float_register_addr, float_register_data,
               float_register_wren, int_to_fp_data, multiplier_data_a, multiplier_data_b,
               divider_data_a, divider_data_b, conv_error, error_addr
    );
endinterface

// File: rtl/element_convert_pipe.sv
// Fully pipelined element converter: element word -> int_to_fp -> x10^(k-6) -> optional 1/x -> float RAM.
// One element issued per clock; a tag shift register follows each element through the external cores
// so results retire in issue order exactly L clocks after their read address was presented.
module element_convert_pipe #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned RAM_LAT  = 1,
    parameter int unsigned CVT_LAT  = 6,
    parameter int unsigned MUL_LAT  = 5,
    parameter int unsigned DIV_LAT  = 6,
    parameter logic [3:0]  INV_MASK = 4'b0001
) (
    input logic                    clk,
    input logic                    program_resetn,
    element_convert_pipe_if.master bus
);
    localparam int L     = int'(RAM_LAT + CVT_LAT + MUL_LAT + DIV_LAT);
    localparam int S_RAM = int'(RAM_LAT) - 1;          // tag stage aligned with element_out
    localparam int S_MUL = S_RAM + int'(CVT_LAT);      // tag stage aligned with int_to_fp_out
    localparam int S_DIV = S_MUL + int'(MUL_LAT);      // tag stage aligned with multiplier_out
    localparam int S_WR  = L - 1;                      // tag stage aligned with divider_out / write

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_t;

    typedef struct packed {
        logic              valid;
        logic              last;
        logic [ADDR_W-1:0] addr;
        logic [1:0]        t;
        logic [3:0]        k;
        logic              vz;
    } tag_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    tag_t              tag_q [L];
    logic [31:0]       byp_q [DIV_LAT];
    tag_t              issue_tag, ram_tag, wr_tag;
    logic              wr_k_err, wr_inv, wr_err;
    logic [31:0]       wr_data;

    // 10^(k-6) as IEEE-754 single; codes above 12 are illegal and yield 0
    function automatic logic [31:0] pow10_rom(input logic [3:0] k);
        case (k)
            4'd0:    return 32'h358637BD;
            4'd1:    return 32'h3727C5AC;
            4'd2:    return 32'h38D1B717;
            4'd3:    return 32'h3A83126F;
            4'd4:    return 32'h3C23D70A;
            4'd5:    return 32'h3DCCCCCD;
            4'd6:    return 32'h3F800000;
            4'd7:    return 32'h41200000;
            4'd8:    return 32'h42C80000;
            4'd9:    return 32'h447A0000;
            4'd10:   return 32'h461C4000;
            4'd11:   return 32'h47C35000;
            4'd12:   return 32'h49742400;
            default: return 32'h00000000;
        endcase
    endfunction

    // Tags entering the pipe on issue, and the same tag enriched with the fields read from RAM
    always_comb begin
        issue_tag       = '0;
        issue_tag.valid = (state_q == StIssue);
        issue_tag.last  = (cnt_q == n_q - 1'b1);
        issue_tag.addr  = cnt_q[ADDR_W-1:0];
        ram_tag         = tag_q[S_RAM];
        ram_tag.t       = bus.element_out[31:30];
        ram_tag.k       = bus.element_out[29:26];
        ram_tag.vz      = (bus.element_out[25:0] == 26'd0);
    end

    // Tag shift register and non-inverted product delay line
    always_ff @(posedge clk or negedge program_resetn) begin
        if (!program_resetn) begin
            for (int j = 0; j < L; j++) tag_q[j] <= '0;
            for (int j = 0; j < int'(DIV_LAT); j++) byp_q[j] <= '0;
        end else begin
            tag_q[0] <= issue_tag;
            for (int j = 1; j < L; j++) tag_q[j] <= (j == S_RAM + 1) ? ram_tag : tag_q[j-1];
            byp_q[0] <= bus.multiplier_out;
            for (int j = 1; j < int'(DIV_LAT); j++) byp_q[j] <= byp_q[j-1];
        end
    end

    // Core operands, gated by the stage valid so idle cycles present zeros
    assign bus.int_to_fp_data    = tag_q[S_RAM].valid ? {6'b0, bus.element_out[25:0]} : 32'h0;
    assign bus.multiplier_data_a = tag_q[S_MUL].valid ? bus.int_to_fp_out : 32'h0;
    assign bus.multiplier_data_b = tag_q[S_MUL].valid ? pow10_rom(tag_q[S_MUL].k) : 32'h0;
    assign bus.divider_data_a    = (tag_q[S_DIV].valid && INV_MASK[tag_q[S_DIV].t]) ?
                                   32'h3F800000 : 32'h0;
    assign bus.divider_data_b    = (tag_q[S_DIV].valid && INV_MASK[tag_q[S_DIV].t]) ?
                                   bus.multiplier_out : 32'h0;

    // Write stage: select divider or bypass, force 0 for an illegal exponent code
    always_comb begin
        wr_tag   = tag_q[S_WR];
        wr_k_err = (wr_tag.k > 4'd12);
        wr_inv   = INV_MASK[wr_tag.t];
        wr_err   = wr_tag.valid & (wr_k_err | (wr_inv & wr_tag.vz));
        wr_data  = 32'h0;
        if (wr_tag.valid && !wr_k_err) wr_data = wr_inv ? bus.divider_out : byp_q[DIV_LAT-1];
    end

    assign bus.float_register_wren = wr_tag.valid;
    assign bus.float_register_addr = wr_tag.valid ? wr_tag.addr : '0;
    assign bus.float_register_data = wr_data;
    assign bus.conv_error          = err_q | wr_err;
    assign bus.error_addr          = err_q ? err_addr_q : (wr_err ? wr_tag.addr : '0);
    assign bus.element_addr        = (state_q == StIssue) ? cnt_q[ADDR_W-1:0] : '0;
    assign bus.busy                = (state_q == StIssue) || (state_q == StDrain);
    assign bus.end_process         = (state_q == StDone);

    // Control FSM next state, issue counter and sticky error capture
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        if (wr_err && !err_q) begin
            err_d      = 1'b1;
            err_addr_d = wr_tag.addr;
        end
        case (state_q)
            StIdle: begin
                if (bus.start_process) begin
                    n_d     = bus.numElements;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = (bus.numElements == '0) ? StDone : StIssue;
                end
            end
            StIssue: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == n_q - 1'b1) state_d = StDrain;
            end
            StDrain: begin
                if (wr_tag.valid && wr_tag.last) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or negedge program_resetn) begin
        if (!program_resetn) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            n_q        <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end
endmodule

// File: tb/tb_element_convert_pipe.sv
// Self-checking bench for element_convert_pipe: element RAM and the three FP cores are modelled
// with real arithmetic; expected results come from a per-element arithmetic reference.
module tb_element_convert_pipe;
    localparam int ADDR_W   = 5;
    localparam int RAM_LAT  = 1;
    localparam int CVT_LAT  = 6;
    localparam int MUL_LAT  = 5;
    localparam int DIV_LAT  = 6;
    localparam logic [3:0] INV_MASK = 4'b0001;
    localparam int L = RAM_LAT + CVT_LAT + MUL_LAT + DIV_LAT;

    logic clk = 1'b0;
    logic program_resetn = 1'b0;
    always #5 clk = ~clk;

    element_convert_pipe_if #(.ADDR_W(ADDR_W)) bus ();

    element_convert_pipe #(
        .ADDR_W(ADDR_W), .RAM_LAT(RAM_LAT), .CVT_LAT(CVT_LAT),
        .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .INV_MASK(INV_MASK)
    ) dut (
        .clk(clk),
        .program_resetn(program_resetn),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- float helpers ----------------
    function automatic logic [31:0] to_sp(input real r);
        logic [63:0] b;
        logic [24:0] mn;
        int          se;
        if (r == 0.0) return 32'h0;
        b = $realtobits(r);
        if (b[62:52] == 11'h7FF) return {b[63], 8'hFF, 23'h0};
        se = int'(b[62:52]) - 1023 + 127;
        mn = {2'b01, b[51:29]};
        if (b[28] && ((|b[27:0]) || mn[0])) mn = mn + 25'd1;
        if (mn[24]) begin
            mn = mn >> 1;
            se = se + 1;
        end
        if (se >= 255) return {b[63], 8'hFF, 23'h0};
        if (se <= 0) return {b[63], 31'h0};
        return {b[63], se[7:0], mn[22:0]};
    endfunction

    function automatic real from_sp(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:23] == 8'h00) return 0.0;
        if (f[30:23] == 8'hFF) e = 11'h7FF;
        else e = 11'(int'(f[30:23]) - 127 + 1023);
        return $bitstoreal({f[31], e, f[22:0], 29'h0});
    endfunction

    // ---------------- environment models ----------------
    logic [31:0] ram [32];
    logic [31:0] cvt_p [CVT_LAT] = '{default: 32'h0};
    logic [31:0] mul_p [MUL_LAT] = '{default: 32'h0};
    logic [31:0] div_p [DIV_LAT] = '{default: 32'h0};

    always @(posedge clk) bus.element_out <= ram[bus.element_addr];

    always @(posedge clk) begin
        cvt_p[0] <= to_sp(real'(bus.int_to_fp_data));
        for (int i = 1; i < CVT_LAT; i++) cvt_p[i] <= cvt_p[i-1];
        mul_p[0] <= to_sp(from_sp(bus.multiplier_data_a) * from_sp(bus.multiplier_data_b));
        for (int i = 1; i < MUL_LAT; i++) mul_p[i] <= mul_p[i-1];
        if (from_sp(bus.divider_data_b) == 0.0) div_p[0] <= 32'h7F800000;
        else div_p[0] <= to_sp(from_sp(bus.divider_data_a) / from_sp(bus.divider_data_b));
        for (int i = 1; i < DIV_LAT; i++) div_p[i] <= div_p[i-1];
    end

    assign bus.int_to_fp_out  = cvt_p[CVT_LAT-1];
    assign bus.multiplier_out = mul_p[MUL_LAT-1];
    assign bus.divider_out    = div_p[DIV_LAT-1];

    // ---------------- reference model ----------------
    function automatic logic [31:0] mk(input int t, input int k, input int v);
        logic [31:0] w;
        w = {t[1:0], k[3:0], v[25:0]};
        return w;
    endfunction

    function automatic bit ref_err(input logic [31:0] w);
        return (w[29:26] > 4'd12) || (INV_MASK[w[31:30]] && (w[25:0] == 26'd0));
    endfunction

    function automatic logic [31:0] ref_value(input logic [31:0] w);
        int  k;
        real scale, prod;
        k = int'(w[29:26]);
        if (k > 12) return 32'h0;
        scale = 1.0;
        for (int i = 0; i < ((k >= 6) ? k - 6 : 6 - k); i++) scale = scale * 10.0;
        if (k < 6) scale = 1.0 / scale;
        prod = from_sp(to_sp(from_sp(to_sp(real'(w[25:0]))) * from_sp(to_sp(scale))));
        if (!INV_MASK[w[31:30]]) return to_sp(prod);
        if (prod == 0.0) return 32'h7F800000;
        return to_sp(1.0 / prod);
    endfunction

    // ---------------- monitor ----------------
    int          wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    int          wr_cyc_q  [$];
    int          end_cyc_q [$];
    int          busy_cnt;

    always @(negedge clk) begin
        if (bus.float_register_wren) begin
            wr_addr_q.push_back(int'(bus.float_register_addr));
            wr_data_q.push_back(bus.float_register_data);
            wr_cyc_q.push_back(cyc);
        end
        if (bus.end_process) end_cyc_q.push_back(cyc);
        if (bus.busy) busy_cnt++;
    end

    task automatic clear_capture();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        end_cyc_q.delete();
        busy_cnt = 0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 32; i++) begin
            int t, k, v;
            t = int'($urandom_range(0, 3));
            k = ($urandom_range(0, 7) == 0) ? int'($urandom_range(13, 15)) : int'($urandom_range(0, 12));
            v = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom & 32'h03FF_FFFF);
            ram[i] = mk(t, k, v);
        end
    endtask

    // Runs one job of n elements and checks every write, timing, end pulse, busy and error flags.
    task automatic run_job(input int n, input bit disturb, input string name);
        int s_cyc, waited, exp_err_addr, nw;
        bit exp_err;
        @(negedge clk);
        clear_capture();
        bus.start_process = 1'b1;
        bus.numElements   = n[ADDR_W:0];
        s_cyc = cyc;
        @(negedge clk);
        bus.start_process = 1'b0;
        if (disturb) begin
            bus.numElements = 6'd3;
            repeat (3) @(negedge clk);
            bus.start_process = 1'b1;
            @(negedge clk);
            bus.start_process = 1'b0;
        end
        waited = 0;
        while (end_cyc_q.size() == 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        repeat (L + 8) @(negedge clk);

        exp_err = 1'b0;
        exp_err_addr = 0;
        for (int i = n - 1; i >= 0; i--) if (ref_err(ram[i])) begin
            exp_err = 1'b1;
            exp_err_addr = i;
        end

        checks++;
        if (end_cyc_q.size() != 1) begin
            errors++;
            $display("FAIL %s end_count: got %0d expected 1", name, end_cyc_q.size());
        end
        if (end_cyc_q.size() >= 1) begin
            checks++;
            if (end_cyc_q[0] != s_cyc + 1 + ((n == 0) ? 0 : L + n)) begin
                errors++;
                $display("FAIL %s end_cycle: got %0d expected %0d", name, end_cyc_q[0] - s_cyc,
                         1 + ((n == 0) ? 0 : L + n));
            end
        end
        checks++;
        if (wr_addr_q.size() != n) begin
            errors++;
            $display("FAIL %s write_count: got %0d expected %0d", name, wr_addr_q.size(), n);
        end
        nw = (wr_addr_q.size() < n) ? wr_addr_q.size() : n;
        for (int i = 0; i < nw; i++) begin
            logic [31:0] exp_d;
            exp_d = ref_value(ram[i]);
            checks++;
            if (wr_addr_q[i] != i) begin
                errors++;
                $display("FAIL %s write_addr[%0d]: got %0d expected %0d", name, i, wr_addr_q[i], i);
            end
            checks++;
            if (wr_data_q[i] !== exp_d) begin
                errors++;
                $display("FAIL %s write_data[%0d]: got %h expected %h (word %h)", name, i,
                         wr_data_q[i], exp_d, ram[i]);
            end
            checks++;
            if (wr_cyc_q[i] != s_cyc + 1 + L + i) begin
                errors++;
                $display("FAIL %s write_cycle[%0d]: got %0d expected %0d", name, i,
                         wr_cyc_q[i] - s_cyc, 1 + L + i);
            end
        end
        checks++;
        if (busy_cnt != ((n == 0) ? 0 : n + L)) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt,
                     (n == 0) ? 0 : n + L);
        end
        checks++;
        if (bus.conv_error !== exp_err) begin
            errors++;
            $display("FAIL %s conv_error: got %b expected %b", name, bus.conv_error, exp_err);
        end
        checks++;
        if (int'(bus.error_addr) != exp_err_addr) begin
            errors++;
            $display("FAIL %s error_addr: got %0d expected %0d", name, bus.error_addr, exp_err_addr);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.start_process = 1'b0;
        bus.numElements   = '0;
        for (int i = 0; i < 32; i++) ram[i] = 32'h0;
        program_resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.end_process, bus.float_register_wren, bus.conv_error} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {bus.busy, bus.end_process, bus.float_register_wren, bus.conv_error});
        end
        checks++;
        if ({bus.element_addr, bus.float_register_addr, bus.error_addr} !== '0) begin
            errors++;
            $display("FAIL reset_addrs: got %h %h %h expected 0", bus.element_addr,
                     bus.float_register_addr, bus.error_addr);
        end
        checks++;
        if ({bus.float_register_data, bus.int_to_fp_data, bus.multiplier_data_b,
             bus.divider_data_a} !== 128'h0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h %h expected 0", bus.float_register_data,
                     bus.int_to_fp_data, bus.multiplier_data_b, bus.divider_data_a);
        end
        program_resetn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_spec_vector();
        ram[0] = mk(0, 6, 100);
        ram[1] = mk(1, 9, 2);
        ram[2] = mk(0, 3, 1);
        run_job(3, 1'b0, "spec_vector");
    endtask

    task automatic test_errors();
        fill_random();
        for (int i = 0; i < 10; i++) ram[i] = mk(1, 6, 1000 + i);
        ram[4] = mk(0, 6, 0);
        ram[7] = mk(1, 15, 5);
        run_job(10, 1'b0, "errors");
        if (wr_data_q.size() > 7) begin
            checks++;
            if (wr_data_q[4] !== 32'h7F800000) begin
                errors++;
                $display("FAIL errors inv_zero: got %h expected 7f800000", wr_data_q[4]);
            end
            checks++;
            if (wr_data_q[7] !== 32'h0) begin
                errors++;
                $display("FAIL errors bad_k: got %h expected 00000000", wr_data_q[7]);
            end
        end
        checks++;
        if (bus.error_addr !== 5'd4) begin
            errors++;
            $display("FAIL errors first_addr: got %0d expected 4", bus.error_addr);
        end
    endtask

    task automatic test_zero_count();
        run_job(0, 1'b0, "zero_count");
    endtask

    task automatic test_full();
        fill_random();
        run_job(32, 1'b0, "full");
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 6; r++) begin
            fill_random();
            run_job(int'($urandom_range(1, 32)), 1'b0, "random");
        end
    endtask

    task automatic test_busy_start();
        fill_random();
        run_job(12, 1'b1, "busy_start");
    endtask

    task automatic test_reset_drain();
        fill_random();
        @(negedge clk);
        bus.start_process = 1'b1;
        bus.numElements   = 6'd20;
        @(negedge clk);
        bus.start_process = 1'b0;
        repeat (21) @(negedge clk);
        checks++;
        if (bus.float_register_wren !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_drain pre: got wren=%b busy=%b expected 1 1",
                     bus.float_register_wren, bus.busy);
        end
        program_resetn = 1'b0;
        #1;
        checks++;
        if (bus.float_register_wren !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_drain same_cycle: got wren=%b busy=%b expected 0 0",
                     bus.float_register_wren, bus.busy);
        end
        @(negedge clk);
        clear_capture();
        repeat (2) @(negedge clk);
        program_resetn = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (wr_addr_q.size() != 0 || end_cyc_q.size() != 0) begin
            errors++;
            $display("FAIL reset_drain after: got writes=%0d ends=%0d expected 0 0",
                     wr_addr_q.size(), end_cyc_q.size());
        end
        run_job(20, 1'b0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_spec_vector();
        test_errors();
        test_zero_count();
        test_full();
        test_back_to_back();
        test_busy_start();
        test_reset_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
